pipe_credit_fifo: RTL and testbench

- Downstream companion to a fixed-latency, non-stallable data delay line that carries no valid and no backpressure.
- Grants issue credits to the producer, tracks each issued beat through a matching internal valid delay line, and captures the delay-line output on arrival.
- Presents the captured beats as an AXI-Stream master with full tready backpressure.
- Guarantees no beat is lost: issue is only allowed while FIFO space plus in-flight beats leave room.

---
 rtl/pipe_credit_fifo.sv | 90 +++++++++
 tb/tb_pipe_credit_fifo.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_credit_fifo.sv
// Purpose: credit-gated capture FIFO behind a fixed-latency, non-stallable delay line; re-emits beats as AXI-Stream.
// Latency: issue at cycle t -> capture at edge t+PIPE_LAT -> m_tvalid at t+PIPE_LAT+1 (no bypass path).
// Backpressure: m_tready stalls the FIFO head; s_issue_ready drops once stored + in-flight beats reach DEPTH.
module pipe_credit_fifo #(
    parameter int DATA_BITS = 32,
    parameter int PIPE_LAT  = 1,
    parameter int DEPTH     = 8
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     s_issue_valid,
    output logic                     s_issue_ready,
    input  logic [DATA_BITS-1:0]     s_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [DATA_BITS-1:0]     m_tdata,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [PIPE_LAT-1:0]  vld_pipe;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic [CW-1:0]        inflight;
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [CW:0]          credit_sum;
    logic                 issue;
    logic                 arrive;
    logic                 pop;

    // Credits come only from registered counters, so ready never combinationally
    // depends on s_issue_valid or m_tready. One spare bit keeps the sum exact.
    assign credit_sum    = {1'b0, count} + {1'b0, inflight};
    assign s_issue_ready = credit_sum < DEPTH_W;
    assign occupancy     = credit_sum[CW-1:0];

    assign issue    = s_issue_valid & s_issue_ready;
    assign arrive   = vld_pipe[PIPE_LAT-1];
    assign m_tvalid = (count != '0);
    assign pop      = m_tvalid & m_tready;
    assign m_tdata  = mem[rd_ptr];

    // Valid shadow of the upstream delay line: stage 0 takes the issue handshake.
    generate
        if (PIPE_LAT == 1) begin : g_lat1
            always_ff @(posedge aclk) begin
                if (areset) vld_pipe <= '0;
                else        vld_pipe <= issue;
            end
        end else begin : g_latn
            always_ff @(posedge aclk) begin
                if (areset) vld_pipe <= '0;
                else        vld_pipe <= {vld_pipe[PIPE_LAT-2:0], issue};
            end
        end
    endgenerate

    // Storage array; capture the delay-line output on the cycle its valid shadow arrives.
    always_ff @(posedge aclk) begin
        if (arrive) mem[wr_ptr] <= s_tdata;
    end

    // Pointers and the stored / in-flight counters.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
        end else begin
            if (arrive) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            inflight <= inflight + CW'(issue)  - CW'(arrive);
            count    <= count    + CW'(arrive) - CW'(pop);
        end
    end

    // The credit scheme must never let stored plus in-flight beats exceed the array.
    a_credit_bound : assert property (@(posedge aclk) disable iff (areset)
        credit_sum <= DEPTH_W);

    // An arrival must always correspond to a beat counted as in flight.
    a_arrive_tracked : assert property (@(posedge aclk) disable iff (areset)
        arrive |-> (inflight != '0));

endmodule

// File: tb/tb_pipe_credit_fifo.sv
// Scoreboarded bench: an upstream delay-line model feeds the DUT, issued beats are queued
// as expectations, and a negedge monitor checks head data, occupancy and credit every cycle.
module tb_pipe_credit_fifo;

    localparam int DATA_BITS = 32;
    localparam int PIPE_LAT  = 3;
    localparam int DEPTH     = 8;

    logic                  clk = 1'b0;
    logic                  areset = 1'b1;
    logic                  s_issue_valid = 1'b0;
    logic                  s_issue_ready;
    logic [DATA_BITS-1:0]  s_tdata;
    logic                  m_tvalid;
    logic                  m_tready = 1'b0;
    logic [DATA_BITS-1:0]  m_tdata;
    logic [$clog2(DEPTH):0] occupancy;

    logic [DATA_BITS-1:0]  issue_dat = '0;
    logic [DATA_BITS-1:0]  up_dat [PIPE_LAT];
    logic [DATA_BITS-1:0]  exp_q [$];
    int                    n_cmp = 0;
    int                    n_err = 0;
    int                    n_pop = 0;
    int                    cyc = 0;
    bit                    chk_en = 1'b0;

    pipe_credit_fifo #(
        .DATA_BITS (DATA_BITS),
        .PIPE_LAT  (PIPE_LAT),
        .DEPTH     (DEPTH)
    ) dut (
        .aclk          (clk),
        .areset        (areset),
        .s_issue_valid (s_issue_valid),
        .s_issue_ready (s_issue_ready),
        .s_tdata       (s_tdata),
        .m_tvalid      (m_tvalid),
        .m_tready      (m_tready),
        .m_tdata       (m_tdata),
        .occupancy     (occupancy)
    );

    always #5 clk = ~clk;

    assign s_tdata = up_dat[PIPE_LAT-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Upstream delay line: carries issued data, otherwise junk that must never be captured.
    // Expectations are queued at the issue handshake and dropped by reset.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = PIPE_LAT - 1; i > 0; i--) up_dat[i] <= up_dat[i-1];
        up_dat[0] <= (s_issue_valid && s_issue_ready) ? issue_dat : (32'hBAD0_0000 | 32'(cyc));
        if (areset) exp_q.delete();
        else if (s_issue_valid && s_issue_ready) exp_q.push_back(issue_dat);
    end

    // Monitor: queue size equals stored + in-flight beats; the head must match while valid.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("occupancy", 64'(occupancy), 64'(exp_q.size()));
            chk("issue_ready", 64'(s_issue_ready), 64'(exp_q.size() < DEPTH));
            if (m_tvalid !== 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_beat: got 0x%0h, expected no beat (t=%0t)", m_tdata, $time);
                end else begin
                    chk("m_tdata", 64'(m_tdata), 64'(exp_q[0]));
                    if (m_tready) begin
                        void'(exp_q.pop_front());
                        n_pop++;
                    end
                end
            end
        end
    end

    initial begin
        int occ_exp [5] = '{1, 1, 1, 1, 0};
        int tv_exp  [5] = '{0, 0, 0, 1, 0};
        int p0;
        int drops;
        int acc;
        int issued;
        int guard;

        // Reset then idle
        repeat (3) next();
        areset = 1'b0;
        chk_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_tvalid", 64'(m_tvalid), 64'd0);
            chk("idle_ready", 64'(s_issue_ready), 64'd1);
            chk("idle_occ", 64'(occupancy), 64'd0);
            next();
        end

        // Single beat: m_tvalid rises PIPE_LAT+1 cycles after the issue
        p0 = n_pop;
        m_tready = 1'b1;
        s_issue_valid = 1'b1;
        issue_dat = 32'hA5A5_0001;
        next();
        s_issue_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("single_occ", 64'(occupancy), 64'(occ_exp[i]));
            chk("single_tvalid", 64'(m_tvalid), 64'(tv_exp[i]));
            next();
        end
        chk("single_pops", 64'(n_pop - p0), 64'd1);

        // Streaming: 100 back-to-back issues, one output per cycle
        p0 = n_pop;
        drops = 0;
        for (int i = 0; i < 100; i++) begin
            s_issue_valid = 1'b1;
            issue_dat = 32'(i);
            @(negedge clk);
            if (!s_issue_ready) drops++;
            next();
        end
        s_issue_valid = 1'b0;
        chk("stream_ready_drops", 64'(drops), 64'd0);
        chk("stream_pops_mid", 64'(n_pop - p0), 64'd96);
        repeat (4) next();
        chk("stream_pops_end", 64'(n_pop - p0), 64'd100);

        // Backpressure: fill to DEPTH, then a single pop frees one credit next cycle
        m_tready = 1'b0;
        acc = 0;
        for (int k = 0; k < 12; k++) begin
            s_issue_valid = 1'b1;
            issue_dat = 32'hB000_0000 + 32'(k);
            @(negedge clk);
            if (s_issue_ready) acc++;
            next();
        end
        s_issue_valid = 1'b0;
        chk("full_accepted", 64'(acc), 64'd8);
        @(negedge clk);
        chk("full_ready", 64'(s_issue_ready), 64'd0);
        chk("full_occ", 64'(occupancy), 64'd8);
        chk("full_head", 64'(m_tdata), 64'h0000_0000_B000_0000);
        next();
        m_tready = 1'b1;
        @(negedge clk);
        chk("pop_cycle_ready", 64'(s_issue_ready), 64'd0);
        next();
        m_tready = 1'b0;
        @(negedge clk);
        chk("after_pop_ready", 64'(s_issue_ready), 64'd1);
        chk("after_pop_occ", 64'(occupancy), 64'd7);
        chk("after_pop_head", 64'(m_tdata), 64'h0000_0000_B000_0001);
        next();
        m_tready = 1'b1;
        repeat (10) next();
        chk("bp_drained", 64'(exp_q.size()), 64'd0);

        // Reset mid-flight: 5 stored and 2 in flight, late arrivals must be ignored
        m_tready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            s_issue_valid = 1'b1;
            issue_dat = 32'hD000_0000 + 32'(k);
            next();
        end
        s_issue_valid = 1'b0;
        @(negedge clk);
        chk("prerst_occ", 64'(occupancy), 64'd7);
        next();
        areset = 1'b1;
        @(negedge clk);
        chk("prerst_tvalid", 64'(m_tvalid), 64'd1);
        next();
        areset = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_tvalid", 64'(m_tvalid), 64'd0);
            chk("rst_occ", 64'(occupancy), 64'd0);
            next();
        end

        // Post-reset sanity beat
        p0 = n_pop;
        s_issue_valid = 1'b1;
        issue_dat = 32'hC0DE_0001;
        next();
        s_issue_valid = 1'b0;
        repeat (6) next();
        chk("post_rst_pops", 64'(n_pop - p0), 64'd1);

        // Random traffic across many pointer wraps
        issued = 0;
        guard = 0;
        while (issued < 1000 && guard < 20000) begin
            s_issue_valid = ($urandom_range(0, 9) < 7);
            m_tready = ($urandom_range(0, 9) < 6);
            issue_dat = $urandom;
            @(negedge clk);
            if (s_issue_valid && s_issue_ready) issued++;
            next();
            guard++;
        end
        s_issue_valid = 1'b0;
        chk("random_issued", 64'(issued), 64'd1000);
        m_tready = 1'b1;
        repeat (20) next();
        chk("random_drained", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        chk("final_tvalid", 64'(m_tvalid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
